// File: rtl/sddr_ctl_init.sv
// ============================================================================
// Module      : sddr_ctl_init
// Description : DDR3 command initiator: RESET#/CKE power-up, MRS/ZQCL init,
//               then free-running periodic REFRESH with a tRFC busy window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sddr_ctl_init #(
    parameter int                  BANK_BITS   = 3,
    parameter int                  ROW_BITS    = 13,
    parameter int                  T_RESET_CYC = 40000,
    parameter int                  T_CKE_CYC   = 100000,
    parameter int                  T_XPR_CYC   = 72,
    parameter int                  T_MRD_CYC   = 4,
    parameter int                  T_MOD_CYC   = 12,
    parameter int                  T_ZQ_CYC    = 512,
    parameter int                  T_REFI_CYC  = 1560,
    parameter int                  T_RFC_CYC   = 32,
    parameter logic [ROW_BITS-1:0] MR0         = '0,
    parameter logic [ROW_BITS-1:0] MR1         = '0,
    parameter logic [ROW_BITS-1:0] MR2         = '0,
    parameter logic [ROW_BITS-1:0] MR3         = '0
) (
    input  logic                 in_ddr_clock_i,
    input  logic                 in_ctl_reset_i,
    output logic                 ddr_reset_n_o,
    output logic                 ctl_cke_o,
    output logic                 ctl_cs_n_o,
    output logic                 ctl_ras_n_o,
    output logic                 ctl_cas_n_o,
    output logic                 ctl_we_n_o,
    output logic [BANK_BITS-1:0] ctl_ba_o,
    output logic [ROW_BITS-1:0]  ctl_addr_o,
    output logic                 ctl_odt_o,
    output logic                 init_done_o,
    output logic                 ref_busy_o
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int c_t_max = f_max(T_RESET_CYC, f_max(T_CKE_CYC, f_max(T_XPR_CYC,
                             f_max(T_MRD_CYC, f_max(T_MOD_CYC, f_max(T_ZQ_CYC, T_REFI_CYC))))));
    localparam int CNT_W   = $clog2(c_t_max + 1);

    // A state entered with load L fires L+1 edges later; reset counts as one
    // edge earlier than cycle 0, hence the full T_RESET load.
    localparam logic [CNT_W-1:0] c_ld_reset = CNT_W'(T_RESET_CYC);
    localparam logic [CNT_W-1:0] c_ld_cke   = CNT_W'(T_CKE_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_xpr   = CNT_W'(T_XPR_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_mrd   = CNT_W'(T_MRD_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_mod   = CNT_W'(T_MOD_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_zq    = CNT_W'(T_ZQ_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_refi  = CNT_W'(T_REFI_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_rfc   = CNT_W'(T_RFC_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_gap   = CNT_W'(T_REFI_CYC - T_RFC_CYC - 1);

    localparam logic [3:0] c_cmd_desel = 4'b1111;
    localparam logic [3:0] c_cmd_nop   = 4'b0111;
    localparam logic [3:0] c_cmd_mrs   = 4'b0000;
    localparam logic [3:0] c_cmd_zqcl  = 4'b0110;
    localparam logic [3:0] c_cmd_ref   = 4'b0001;

    localparam logic [ROW_BITS-1:0] c_zq_addr = ROW_BITS'(11'h400);

    localparam logic [3:0] c_st_rst_low  = 4'd0;
    localparam logic [3:0] c_st_cke_wait = 4'd1;
    localparam logic [3:0] c_st_xpr_wait = 4'd2;
    localparam logic [3:0] c_st_mr2_wait = 4'd3;
    localparam logic [3:0] c_st_mr3_wait = 4'd4;
    localparam logic [3:0] c_st_mr1_wait = 4'd5;
    localparam logic [3:0] c_st_mod_wait = 4'd6;
    localparam logic [3:0] c_st_zq_wait  = 4'd7;
    localparam logic [3:0] c_st_idle     = 4'd8;
    localparam logic [3:0] c_st_ref      = 4'd9;

    logic [3:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ddr_reset_n_q, ddr_reset_n_d;
    logic                 cke_q, cke_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [BANK_BITS-1:0] ba_q, ba_d;
    logic [ROW_BITS-1:0]  addr_q, addr_d;
    logic                 init_done_q, init_done_d;
    logic                 ref_busy_q, ref_busy_d;
    logic                 w_fire;

    assign w_fire = (cnt_q == '0);

    always_ff @(posedge in_ddr_clock_i) begin
        if (in_ctl_reset_i) begin
            state_q       <= c_st_rst_low;
            cnt_q         <= c_ld_reset;
            ddr_reset_n_q <= 1'b0;
            cke_q         <= 1'b0;
            cmd_q         <= c_cmd_desel;
            ba_q          <= '0;
            addr_q        <= '0;
            init_done_q   <= 1'b0;
            ref_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ddr_reset_n_q <= ddr_reset_n_d;
            cke_q         <= cke_d;
            cmd_q         <= cmd_d;
            ba_q          <= ba_d;
            addr_q        <= addr_d;
            init_done_q   <= init_done_d;
            ref_busy_q    <= ref_busy_d;
        end
    end

    // REF reloads with the remainder of tREFI so the interval stays start-to-start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (w_fire) begin
            case (state_q)
                c_st_rst_low:  begin state_d = c_st_cke_wait; cnt_d = c_ld_cke;   end
                c_st_cke_wait: begin state_d = c_st_xpr_wait; cnt_d = c_ld_xpr;   end
                c_st_xpr_wait: begin state_d = c_st_mr2_wait; cnt_d = c_ld_mrd;   end
                c_st_mr2_wait: begin state_d = c_st_mr3_wait; cnt_d = c_ld_mrd;   end
                c_st_mr3_wait: begin state_d = c_st_mr1_wait; cnt_d = c_ld_mrd;   end
                c_st_mr1_wait: begin state_d = c_st_mod_wait; cnt_d = c_ld_mod;   end
                c_st_mod_wait: begin state_d = c_st_zq_wait;  cnt_d = c_ld_zq;    end
                c_st_zq_wait:  begin state_d = c_st_idle;     cnt_d = c_ld_refi;  end
                c_st_idle:     begin state_d = c_st_ref;      cnt_d = c_ld_rfc;   end
                c_st_ref:      begin state_d = c_st_idle;     cnt_d = c_ld_gap;   end
                default:       begin state_d = c_st_rst_low;  cnt_d = c_ld_reset; end
            endcase
        end
    end

    always_comb begin
        ddr_reset_n_d = ddr_reset_n_q | (w_fire && (state_q == c_st_rst_low));
        cke_d         = cke_q | (w_fire && (state_q == c_st_cke_wait));
        init_done_d   = init_done_q | (w_fire && (state_q == c_st_zq_wait));
        ref_busy_d    = (state_d == c_st_ref);
        cmd_d         = cke_d ? c_cmd_nop : c_cmd_desel;
        ba_d          = '0;
        addr_d        = '0;
        if (w_fire) begin
            case (state_q)
                c_st_xpr_wait: begin cmd_d = c_cmd_mrs;  ba_d = BANK_BITS'(2); addr_d = MR2; end
                c_st_mr2_wait: begin cmd_d = c_cmd_mrs;  ba_d = BANK_BITS'(3); addr_d = MR3; end
                c_st_mr3_wait: begin cmd_d = c_cmd_mrs;  ba_d = BANK_BITS'(1); addr_d = MR1; end
                c_st_mr1_wait: begin cmd_d = c_cmd_mrs;  ba_d = BANK_BITS'(0); addr_d = MR0; end
                c_st_mod_wait: begin cmd_d = c_cmd_zqcl; addr_d = c_zq_addr; end
                c_st_idle:     begin cmd_d = c_cmd_ref; end
                default:       ;
            endcase
        end
    end

    assign ddr_reset_n_o = ddr_reset_n_q;
    assign ctl_cke_o     = cke_q;
    assign ctl_cs_n_o    = cmd_q[3];
    assign ctl_ras_n_o   = cmd_q[2];
    assign ctl_cas_n_o   = cmd_q[1];
    assign ctl_we_n_o    = cmd_q[0];
    assign ctl_ba_o      = ba_q;
    assign ctl_addr_o    = addr_q;
    assign ctl_odt_o     = 1'b0;
    assign init_done_o   = init_done_q;
    assign ref_busy_o    = ref_busy_q;

endmodule

`default_nettype wire
